// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Optional blink support in seg_scan_ctrl is enabled with the SEG_SCAN_BLINK_EN macro.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK    = 8'hFF;
  localparam int         BLINK_FRAMES = 32;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Codes above 9 decode to all segments off.
module bcd_to_7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with guard gaps and frame-aligned loading.
// Define SEG_SCAN_BLINK_EN to add the blink_in port and the 32-frame blink phase.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
  input  logic                    load,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);

  localparam int CNT_MAX = max_int(ON_CYCLES, GUARD_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] ON_PRE     = CW'(ON_CYCLES - 2);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  logic [4*NUM_DIGITS-1:0] sh_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   sh_en, pend_en;
  logic [NUM_DIGITS-1:0]   sh_dp, pend_dp;
  logic                    pending;

`ifdef SEG_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0] sh_blink, pend_blink;
  logic [4:0]            frame_cnt;
  logic                  phase;
`endif

  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;
  logic [7:0] slot_seg;
  logic       frame_end;

  assign cur_bcd = sh_digits[4*idx +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Blanking and dp are resolved here so the decoder stays a pure lookup.
  always_comb begin
    slot_seg = SEG_BLANK;
    if (sh_en[idx] && (cur_bcd <= 4'd9)) slot_seg = {~sh_dp[idx], dec_seg};
`ifdef SEG_SCAN_BLINK_EN
    if (phase && sh_blink[idx]) slot_seg = SEG_BLANK;
`endif
  end

  assign frame_end = (state == ST_ON) && (cnt == ON_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_GUARD;
      idx         <= '0;
      cnt         <= '0;
      seg_out     <= SEG_BLANK;
      dig_sel_n   <= '1;
      frame_done  <= 1'b0;
      sh_digits   <= '0;
      sh_en       <= '0;
      sh_dp       <= '0;
      pend_digits <= '0;
      pend_en     <= '0;
      pend_dp     <= '0;
      pending     <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      sh_blink    <= '0;
      pend_blink  <= '0;
      frame_cnt   <= '0;
      phase       <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state     <= ST_ON;
            cnt       <= '0;
            dig_sel_n <= ~(NUM_DIGITS'(1) << idx);
            seg_out   <= slot_seg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ON: begin
          // Registered pulse lands on the final ON cycle of the last digit.
          frame_done <= (idx == IDX_LAST) && (cnt == ON_PRE);
          if (cnt == ON_LAST) begin
            state     <= ST_GUARD;
            cnt       <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            dig_sel_n <= '1;
            seg_out   <= SEG_BLANK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_GUARD;
          cnt   <= '0;
        end
      endcase

      // Shadow only changes at the frame boundary, so a frame never mixes data.
      if (load && frame_end) begin
        sh_digits <= digits_in;
        sh_en     <= en_in;
        sh_dp     <= dp_in;
`ifdef SEG_SCAN_BLINK_EN
        sh_blink  <= blink_in;
`endif
        pending   <= 1'b0;
      end else begin
        if (load) begin
          pend_digits <= digits_in;
          pend_en     <= en_in;
          pend_dp     <= dp_in;
`ifdef SEG_SCAN_BLINK_EN
          pend_blink  <= blink_in;
`endif
          pending     <= 1'b1;
        end
        if (frame_end && pending) begin
          sh_digits <= pend_digits;
          sh_en     <= pend_en;
          sh_dp     <= pend_dp;
`ifdef SEG_SCAN_BLINK_EN
          sh_blink  <= pend_blink;
`endif
          pending   <= 1'b0;
        end
      end

`ifdef SEG_SCAN_BLINK_EN
      if (frame_end) begin
        frame_cnt <= frame_cnt + 5'd1;
        if (frame_cnt == 5'(BLINK_FRAMES - 1)) phase <= ~phase;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 8 ON cycles, 2 guard cycles) with an expected-output queue.
// Blink checks are included when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int ON    = 8;
  localparam int GUARD = 2;
  localparam int SLOT  = ON + GUARD;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   en_in;
  logic [N-1:0]   dp_in;
`ifdef SEG_SCAN_BLINK_EN
  logic [N-1:0]   blink_in;
`endif
  logic           load;
  logic [7:0]     seg_out;
  logic [N-1:0]   dig_sel_n;
  logic           frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .ON_CYCLES    (ON),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .en_in      (en_in),
    .dp_in      (dp_in),
`ifdef SEG_SCAN_BLINK_EN
    .blink_in   (blink_in),
`endif
    .load       (load),
    .seg_out    (seg_out),
    .dig_sel_n  (dig_sel_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model state: cycle index since the last reset edge, displayed and queued data.
  int             t;
  logic [4*N-1:0] cur_dig, nxt_dig;
  logic [N-1:0]   cur_en, nxt_en, cur_dp, nxt_dp, cur_bl, nxt_bl;
  logic           nxt_v;

  logic [12:0] exp_q[$];
  int vecs = 0;
  int errs = 0;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [12:0] expect_at(input int tc);
    int slot, pos;
    logic [3:0] d, sel;
    logic [7:0] s;
    logic fd;
    slot = (tc / SLOT) % N;
    pos  = tc % SLOT;
    if (pos < GUARD) return {8'hFF, 4'hF, 1'b0};
    sel = 4'hF;
    sel[slot] = 1'b0;
    d = cur_dig[4*slot +: 4];
    s = 8'hFF;
    if (cur_en[slot] && d <= 4'd9) s = {~cur_dp[slot], seg7(d)};
`ifdef SEG_SCAN_BLINK_EN
    if ((((tc / FRAME) / 32) % 2 == 1) && cur_bl[slot]) s = 8'hFF;
`endif
    fd = (slot == N - 1) && (pos == SLOT - 1);
    return {s, sel, fd};
  endfunction

  task automatic check();
    logic [12:0] obs, expv;
    obs = {seg_out, dig_sel_n, frame_done};
    vecs++;
    if (exp_q.size() == 0) begin
      errs++;
      $error("FAIL queue_empty t=%0d observed=%h expected=<none>", t, obs);
      return;
    end
    expv = exp_q.pop_front();
    assert (obs === expv) else begin
      errs++;
      $error("FAIL scan t=%0d observed seg=%h sel=%h fd=%b expected seg=%h sel=%h fd=%b",
             t, obs[12:5], obs[4:1], obs[0], expv[12:5], expv[4:1], expv[0]);
    end
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] e,
                      input logic [3:0] p, input logic [3:0] b);
    check();
    load      = ld;
    digits_in = d;
    en_in     = e;
    dp_in     = p;
`ifdef SEG_SCAN_BLINK_EN
    blink_in  = b;
`endif
    if (ld) begin
      nxt_dig = d; nxt_en = e; nxt_dp = p; nxt_bl = b; nxt_v = 1'b1;
    end
    @(posedge clk);
    t++;
    if ((t % FRAME == 0) && nxt_v) begin
      cur_dig = nxt_dig; cur_en = nxt_en; cur_dp = nxt_dp; cur_bl = nxt_bl; nxt_v = 1'b0;
    end
    exp_q.push_back(expect_at(t));
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (t < target) tick(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic do_reset(input int n);
    if (exp_q.size() != 0) check();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (n) @(posedge clk);
    t = 0;
    cur_dig = '0; cur_en = '0; cur_dp = '0; cur_bl = '0; nxt_v = 1'b0;
    exp_q.delete();
    exp_q.push_back(expect_at(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int off;
    rst_n = 1'b0;
    load = 1'b0;
    digits_in = '0;
    en_in = '0;
    dp_in = '0;
`ifdef SEG_SCAN_BLINK_EN
    blink_in = '0;
`endif
    t = 0;
    @(negedge clk);

    // Reset, then a blank-data frame with loading of 4321 requested mid-frame.
    do_reset(3);
    run_to(5);
    tick(1'b1, 16'h4321, 4'hF, 4'h0, 4'h0);
    run_to(2 * FRAME);

    // Blanking of disabled and out-of-range digits, dp on digit 0.
    run_to(2 * FRAME + 20);
    tick(1'b1, 16'hF0A5, 4'b1101, 4'b0001, 4'h0);
    run_to(4 * FRAME);

    // Two loads inside one frame: last one wins, current frame keeps old data.
    run_to(4 * FRAME + 15);
    tick(1'b1, 16'h1111, 4'hF, 4'h0, 4'h0);
    tick(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    tick(1'b1, 16'h2222, 4'hF, 4'h0, 4'h0);

    // Load coincident with the transfer goes straight to the display.
    run_to(6 * FRAME - 1);
    tick(1'b1, 16'h9876, 4'hF, 4'b1010, 4'h0);
    run_to(7 * FRAME);

    // Random loads at random points within successive frames.
    for (int f = 7; f < 10; f++) begin
      off = $urandom_range(0, FRAME - 1);
      run_to(f * FRAME + off);
      tick(1'b1, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'h0);
    end
    run_to(11 * FRAME);

    // Reset in the middle of digit 2's ON time clears everything.
    run_to(11 * FRAME + 2 * SLOT + 5);
    do_reset(1);
    run_to(FRAME + 5);

`ifdef SEG_SCAN_BLINK_EN
    do_reset(2);
    run_to(5);
    tick(1'b1, 16'h8888, 4'hF, 4'h0, 4'b0001);
    run_to(66 * FRAME);
`endif

    check();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
